div_unit: RTL
=============

# div_unit

Iterative RV64M divider for the execute stage. It consumes the two source operands read from the register file, together with the destination index, and computes DIV/DIVU/REM/REMU and their 32-bit W variants. It uses a radix-2 restoring algorithm that produces one quotient bit per cycle. The result and `rd_index` are presented to the writeback path through a valid/ready handshake, and the writeback path drives the register-file write port.

## Interface
- `XLEN`, 64: operand/result width; the index width is fixed at 5.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: synchronous kill of any in-flight or held operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: high only in IDLE with `rst` low.
- `op` input 2: operation select.
  - 00 = DIV
  - 01 = DIVU
  - 10 = REM
  - 11 = REMU
- `word` input 1: selects the W variant (32-bit operation, sign-extended result).
- `rs1_data` input XLEN: dividend.
- `rs2_data` input XLEN: divisor.
- `rd_index` input 5: destination register, carried through unchanged.
- `out_valid` output 1: result valid.
- `out_ready` input 1: writeback accepts the result.
- `out_data` output XLEN: result.
- `out_rd_index` output 5: destination register of `out_data`.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE → accept:** an operation is accepted when `in_valid && in_ready && !flush`. On accept, the block latches `op`, `word`, `rd_index` and the operands.
- **Word operands:** when `word=1`, operands are the low 32 bits. They are sign-extended for DIV/REM and zero-extended for DIVU/REMU, and the iteration count N is 32. Otherwise N=64.
- **Signed magnitudes:** for signed ops the divider works on absolute values. Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend).
- **Divide by zero** (divisor = 0 in the operative width):
  - Go IDLE → DONE directly.
  - Quotient = all ones; remainder = dividend.
- **Signed overflow** (DIV/REM, dividend = most-negative in operative width, divisor = −1):
  - Go IDLE → DONE directly.
  - Quotient = dividend; remainder = 0.
- **Otherwise:** go IDLE → CALC. Each CALC cycle shifts one dividend bit into the partial remainder and subtracts the divisor. If the difference is non-negative, the remainder takes the difference and a quotient bit 1 is written; otherwise a 0 is written. A 7-bit counter stops CALC after exactly N iterations.
- **CALC → DONE:** the sign-corrected result is registered into `out_data` on the final iteration.
- **W result formatting:** the 32-bit result is sign-extended to 64 bits for all four ops, including DIVUW/REMUW.
- **DONE → IDLE:** on `out_ready`. No new operation is accepted in the same cycle.
- **Back-pressure:** while in DONE with `out_ready` low, `out_data` and `out_rd_index` are held stable.
- **flush:** in any state, the next state is IDLE and `out_valid` goes low next cycle. `flush` takes priority over `in_valid` and `out_ready` in the same cycle.
- **rst:** takes priority over everything. State returns to IDLE, the counter is cleared, and `out_valid` = 0, `out_data` = 0, `out_rd_index` = 0.

## Timing
- **Normal latency:** accept in cycle c. Iterations run in cycles c+1 … c+N. `out_valid` is high from cycle c+N+1, so 65 cycles for 64-bit ops and 33 for W ops.
- **Special-case latency:** divide-by-zero and overflow raise `out_valid` in cycle c+1.
- **Throughput:** at most one operation per N+2 cycles. `in_ready` is low from cycle c+1 until the cycle after the result handshake.
- **Register-file dependency:** `out_*` are registered outputs with no combinational path from the inputs. `in_ready` depends only on state and `rst`.
- **Reset mid-operation:** `rst` during CALC or DONE discards the operation, with no output. `in_ready` is high in the cycle after `rst` deasserts.

## Test plan
- **DIV and REM, negative dividend:** DIV with `rs1`=−7 and `rs2`=2 gives `out_data` = 0xFFFF_FFFF_FFFF_FFFD (−3) at cycle c+65. REM with the same operands gives 0xFFFF_FFFF_FFFF_FFFF (−1). `out_rd_index` equals the `rd_index` presented at accept.
- **DIVU and REMU:** DIVU 100/7 gives 14 and REMU 100/7 gives 2. With `out_ready` held low for 5 cycles after `out_valid`, `out_data` stays stable, and `in_valid` asserted during that time is not accepted.
- **Divide by zero:** DIVU 5/0 gives 0xFFFF_FFFF_FFFF_FFFF at c+1. REM 5/0 gives 5 at c+1. No CALC cycles occur.
- **Signed overflow:**
  - DIV 0x8000_0000_0000_0000 / −1 gives 0x8000_0000_0000_0000 at c+1.
  - REM with the same operands gives 0.
  - DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF_FFFF_FFFF gives 0xFFFF_FFFF_8000_0000.
- **DIVUW:** `rs1`=0x1234_5678_FFFF_FFFE and `rs2`=1 give 0xFFFF_FFFF_FFFF_FFFE at c+33.
- **flush and rst mid-operation:**
  - `flush` at c+10 of a 64-bit DIV: `out_valid` never rises, and `in_ready` is high at c+11. A new DIVU 9/3 accepted at c+11 returns 3 at c+76.
  - `rst` at c+20: all outputs read 0 in the following cycle.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface div_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            word;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_index;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd_index;

  modport master (
    output in_valid, op, word, rs1_data, rs2_data, rd_index, out_ready,
    input  in_ready, out_valid, out_data, out_rd_index
  );

  modport slave (
    input  in_valid, op, word, rs1_data, rs2_data, rd_index, out_ready,
    output in_ready, out_valid, out_data, out_rd_index
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input logic  clk,
  input logic  rst,
  input logic  flush,
  div_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            is_rem_q, is_rem_d;
  logic            word_q, word_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [4:0]      out_rd_q, out_rd_d;

  function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation for a request presented in IDLE.
  logic            is_signed, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_min;

  always_comb begin
    is_signed = ~bus.op[0];
    if (bus.word) begin
      a_ext = is_signed ? {{(XLEN-32){bus.rs1_data[31]}}, bus.rs1_data[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.rs1_data[31:0]};
      b_ext = is_signed ? {{(XLEN-32){bus.rs2_data[31]}}, bus.rs2_data[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.rs2_data[31:0]};
      a_min = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext = bus.rs1_data;
      b_ext = bus.rs2_data;
      a_min = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = is_signed && (a_ext == a_min) && (b_ext == '1);
  end

  // One restoring step; the dividend is shifted out of the top of quo_q while
  // quotient bits enter at the bottom.
  logic [XLEN:0]   shifted, diff;
  logic            step_ok;
  logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    step_ok  = ~diff[XLEN];
    step_rem = step_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], step_ok};
    q_fix    = qneg_q ? -step_quo : step_quo;
    r_fix    = rneg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    is_rem_d   = is_rem_q;
    word_d     = word_q;
    rd_d       = rd_q;
    out_data_d = out_data_q;
    out_rd_d   = out_rd_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && !flush) begin
          is_rem_d = bus.op[1];
          word_d   = bus.word;
          rd_d     = bus.rd_index;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          if (div_zero) begin
            out_data_d = fmt(bus.word, bus.op[1] ? a_ext : '1);
            out_rd_d   = bus.rd_index;
            state_d    = StDone;
          end else if (ovf) begin
            out_data_d = fmt(bus.word, bus.op[1] ? '0 : a_ext);
            out_rd_d   = bus.rd_index;
            state_d    = StDone;
          end else begin
            // W dividends sit in the upper half so their MSB is shifted out first.
            quo_d   = bus.word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            cnt_d   = bus.word ? 7'd32 : 7'd64;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          out_data_d = fmt(word_q, is_rem_q ? r_fix : q_fix);
          out_rd_d   = rd_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      is_rem_q   <= 1'b0;
      word_q     <= 1'b0;
      rd_q       <= '0;
      out_data_q <= '0;
      out_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      is_rem_q   <= is_rem_d;
      word_q     <= word_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      out_rd_q   <= out_rd_d;
    end
  end

  assign bus.in_ready     = (state_q == StIdle) && !rst;
  assign bus.out_valid    = (state_q == StDone);
  assign bus.out_data     = out_data_q;
  assign bus.out_rd_index = out_rd_q;

endmodule
